// File: rtl/csr_sequencer.sv
// csr_sequencer: machine-mode CSR file with a serializing access FSM.
// Every CSR instruction is read in READ and committed in WRITE. Traps and
// MRETs each take one cycle and pulse a fetch redirect.
module csr_sequencer #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_rs1_data,
  input  logic [4:0]  req_rs1_idx,
  output logic        resp_valid,
  output logic [31:0] resp_rd_data,
  output logic        resp_illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mstatus_mie
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_TRAP, S_MRET} state_e;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs1_idx;
  } csr_req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] tval;
  } trap_req_t;

  state_e      state_q, state_d;
  csr_req_t    req_q, req_d;
  trap_req_t   trap_q, trap_d;
  logic [31:0] old_q, old_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        ill_q, ill_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mie_csr_q, mie_csr_d;
  logic [63:0] mcycle_q, mcycle_d;

  logic [31:0] rd_val, src, wdata_calc;
  logic        rd_impl, suppress, illegal;

  // Read mux for the latched address plus the access legality decode.
  always_comb begin
    rd_val  = '0;
    rd_impl = 1'b1;
    case (req_q.addr)
      A_MSTATUS:  rd_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      A_MISA:     rd_val = MISA_VALUE;
      A_MIE:      rd_val = mie_csr_q;
      A_MTVEC:    rd_val = mtvec_q;
      A_MSCRATCH: rd_val = mscratch_q;
      A_MEPC:     rd_val = mepc_q;
      A_MCAUSE:   rd_val = mcause_q;
      A_MTVAL:    rd_val = mtval_q;
      A_MCYCLE:   rd_val = mcycle_q[31:0];
      A_MCYCLEH:  rd_val = mcycle_q[63:32];
      default:    rd_impl = 1'b0;
    endcase
    src = req_q.funct3[2] ? {27'b0, req_q.rs1_idx} : req_q.rs1_data;
    case (req_q.funct3[1:0])
      2'b10:   wdata_calc = rd_val | src;
      2'b11:   wdata_calc = rd_val & ~src;
      default: wdata_calc = src;
    endcase
    // set/clear forms with x0 / zimm=0 are pure reads
    suppress = req_q.funct3[1] && (req_q.rs1_idx == 5'd0);
    illegal  = (req_q.funct3[1:0] == 2'b00) || !rd_impl ||
               (!suppress && (req_q.addr[11:10] == 2'b11));
  end

  // Next-state, CSR updates and the free-running cycle counter.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    trap_d     = trap_q;
    old_d      = old_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    ill_d      = ill_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mscratch_d = mscratch_q;
    mie_csr_d  = mie_csr_q;
    mcycle_d   = mcycle_q + 64'd1;
    case (state_q)
      S_IDLE: begin
        if (trap_valid) begin
          trap_d  = '{pc: trap_pc, cause: trap_cause, tval: trap_tval};
          state_d = S_TRAP;
        end else if (mret_valid) begin
          state_d = S_MRET;
        end else if (req_valid) begin
          req_d   = '{funct3: req_funct3, addr: req_addr,
                      rs1_data: req_rs1_data, rs1_idx: req_rs1_idx};
          state_d = S_READ;
        end
      end
      S_READ: begin
        old_d   = illegal ? 32'd0 : rd_val;
        wdata_d = wdata_calc;
        we_d    = !suppress && !illegal;
        ill_d   = illegal;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (we_q) begin
          case (req_q.addr)
            A_MSTATUS: begin
              mie_d  = wdata_q[3];
              mpie_d = wdata_q[7];
            end
            A_MIE:      mie_csr_d  = wdata_q;
            A_MTVEC:    mtvec_d    = wdata_q & 32'hFFFF_FFFC;
            A_MSCRATCH: mscratch_d = wdata_q;
            A_MEPC:     mepc_d     = wdata_q & 32'hFFFF_FFFC;
            A_MCAUSE:   mcause_d   = wdata_q;
            A_MTVAL:    mtval_d    = wdata_q;
            A_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wdata_q};
            A_MCYCLEH:  mcycle_d   = {wdata_q, mcycle_q[31:0]};
            default: ;
          endcase
        end
        state_d = S_IDLE;
      end
      S_TRAP: begin
        mepc_d   = trap_q.pc & 32'hFFFF_FFFC;
        mcause_d = trap_q.cause;
        mtval_d  = trap_q.tval;
        mpie_d   = mie_q;
        mie_d    = 1'b0;
        state_d  = S_IDLE;
      end
      S_MRET: begin
        mie_d   = mpie_q;
        mpie_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and CSR registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      trap_q     <= '0;
      old_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      ill_q      <= 1'b0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & 32'hFFFF_FFFC;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mscratch_q <= '0;
      mie_csr_q  <= '0;
      mcycle_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      trap_q     <= trap_d;
      old_q      <= old_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      ill_q      <= ill_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mscratch_q <= mscratch_d;
      mie_csr_q  <= mie_csr_d;
      mcycle_q   <= mcycle_d;
    end
  end

  // Outputs decode straight from state so they are glitch-free per cycle.
  always_comb begin
    req_ready      = (state_q == S_IDLE);
    resp_valid     = (state_q == S_WRITE);
    resp_illegal   = (state_q == S_WRITE) && ill_q;
    resp_rd_data   = old_q;
    redirect_valid = (state_q == S_TRAP) || (state_q == S_MRET);
    redirect_pc    = (state_q == S_TRAP) ? mtvec_q :
                     (state_q == S_MRET) ? mepc_q : 32'd0;
    mstatus_mie    = mie_q;
  end

endmodule

// File: tb/tb_csr_sequencer.sv
// Bench for csr_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_csr_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, trap_valid = 1'b0, mret_valid = 1'b0;
  logic        req_ready, resp_valid, resp_illegal, redirect_valid, mstatus_mie;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_rs1_data = '0, trap_pc = '0, trap_cause = '0, trap_tval = '0;
  logic [4:0]  req_rs1_idx = '0;
  logic [31:0] resp_rd_data, redirect_pc;

  always #5 clk = ~clk;

  csr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_rs1_data(req_rs1_data),
    .req_rs1_idx(req_rs1_idx), .resp_valid(resp_valid), .resp_rd_data(resp_rd_data),
    .resp_illegal(resp_illegal), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .trap_tval(trap_tval), .mret_valid(mret_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mstatus_mie(mstatus_mie)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_miereg;
  logic [63:0] m_cyc;
  int          cyc, idle_from, p_kind, p_edge;   // p_kind: 0 none, 1 csr, 2 trap, 3 mret
  bit          exp_ready, exp_rv, exp_ill, exp_redir, p_we;
  logic [31:0] exp_rd, exp_rpc, p_d, p_wdata, p_tpc, p_tcause, p_ttval;
  logic [2:0]  p_f3;
  logic [11:0] p_addr;
  logic [4:0]  p_idx;

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit impl);
    logic [31:0] r;
    impl = 1'b1;
    case (a)
      12'h300: r = 32'h1800 + (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
      12'h301: r = 32'h4000_0100;
      12'h304: r = m_miereg;
      12'h305: r = m_mtvec;
      12'h340: r = m_mscratch;
      12'h341: r = m_mepc;
      12'h342: r = m_mcause;
      12'h343: r = m_mtval;
      12'hB00: r = m_cyc[31:0];
      12'hB80: r = m_cyc[63:32];
      default: begin r = 32'h0; impl = 1'b0; end
    endcase
    return r;
  endfunction

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_miereg = 0; m_cyc = 0;
    cyc = 0; idle_from = 0; p_kind = 0; p_edge = 0;
    exp_ready = 1; exp_rv = 0; exp_ill = 0; exp_redir = 0; exp_rd = 0; exp_rpc = 0;
  endtask

  // One clock edge: a CSR access reads one edge after acceptance and
  // commits one edge later; traps and mrets commit one edge after acceptance.
  task automatic m_step();
    bit was_idle, impl, supp, ill, inc;
    logic [31:0] old, src;
    was_idle = exp_ready;
    cyc++;
    exp_rv = 0; exp_redir = 0; inc = 1;
    if (p_kind == 1 && cyc == p_edge + 1) begin
      old  = m_read(p_addr, impl);
      supp = (p_f3 == 3'b010 || p_f3 == 3'b011 || p_f3 == 3'b110 || p_f3 == 3'b111) && p_idx == 0;
      ill  = (p_f3 == 3'b000 || p_f3 == 3'b100) || !impl || (!supp && p_addr >= 12'hC00);
      src  = (p_f3 >= 3'b100) ? 32'(p_idx) : p_d;
      if (p_f3 == 3'b010 || p_f3 == 3'b110)      p_wdata = old | src;
      else if (p_f3 == 3'b011 || p_f3 == 3'b111) p_wdata = old & ~src;
      else                                       p_wdata = src;
      p_we = !supp && !ill;
      exp_rv = 1; exp_ill = ill; exp_rd = ill ? 32'h0 : old;
    end
    if (p_kind == 1 && cyc == p_edge + 2) begin
      if (p_we) begin
        case (p_addr)
          12'h300: begin m_mie = p_wdata[3]; m_mpie = p_wdata[7]; end
          12'h304: m_miereg = p_wdata;
          12'h305: m_mtvec = {p_wdata[31:2], 2'b00};
          12'h340: m_mscratch = p_wdata;
          12'h341: m_mepc = {p_wdata[31:2], 2'b00};
          12'h342: m_mcause = p_wdata;
          12'h343: m_mtval = p_wdata;
          12'hB00: begin m_cyc[31:0] = p_wdata; inc = 0; end
          12'hB80: begin m_cyc[63:32] = p_wdata; inc = 0; end
          default: ;
        endcase
      end
      p_kind = 0;
    end else if (p_kind == 2 && cyc == p_edge + 1) begin
      m_mepc = {p_tpc[31:2], 2'b00}; m_mcause = p_tcause; m_mtval = p_ttval;
      m_mpie = m_mie; m_mie = 0; p_kind = 0;
    end else if (p_kind == 3 && cyc == p_edge + 1) begin
      m_mie = m_mpie; m_mpie = 1; p_kind = 0;
    end
    if (inc) m_cyc = m_cyc + 64'd1;
    if (was_idle) begin
      if (trap_valid) begin
        p_kind = 2; p_edge = cyc; p_tpc = trap_pc; p_tcause = trap_cause; p_ttval = trap_tval;
        exp_redir = 1; exp_rpc = m_mtvec; idle_from = cyc + 1;
      end else if (mret_valid) begin
        p_kind = 3; p_edge = cyc; exp_redir = 1; exp_rpc = m_mepc; idle_from = cyc + 1;
      end else if (req_valid) begin
        p_kind = 1; p_edge = cyc; p_f3 = req_funct3; p_addr = req_addr;
        p_d = req_rs1_data; p_idx = req_rs1_idx; idle_from = cyc + 2;
      end
    end
    exp_ready = (cyc >= idle_from);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    check("req_ready", req_ready, exp_ready);
    check("resp_valid", resp_valid, exp_rv);
    if (exp_rv) begin
      check("resp_illegal", resp_illegal, exp_ill);
      check("resp_rd_data", resp_rd_data, exp_rd);
    end
    check("redirect_valid", redirect_valid, exp_redir);
    if (exp_redir) check("redirect_pc", redirect_pc, exp_rpc);
    check("mstatus_mie", mstatus_mie, m_mie);
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) check("ready_timeout", req_ready, 1);
  endtask

  task automatic scramble();
    req_funct3 = 3'($urandom); req_addr = 12'($urandom);
    req_rs1_data = $urandom; req_rs1_idx = 5'($urandom);
    trap_pc = $urandom; trap_cause = $urandom; trap_tval = $urandom;
  endtask

  task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                        input logic [4:0] idx, output logic [31:0] rd, output bit ill,
                        output int lat);
    int n;
    @(negedge clk);
    wait_ready();
    req_valid = 1; req_funct3 = f3; req_addr = a; req_rs1_data = d; req_rs1_idx = idx;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    scramble();
    lat = 1; n = 0;
    while (!resp_valid && n < 10) begin @(negedge clk); lat++; n++; end
    if (!resp_valid) check("resp_timeout", resp_valid, 1);
    rd = resp_rd_data; ill = resp_illegal;
  endtask

  task automatic issue(input bit tv, input bit mv, input bit rv);
    @(negedge clk);
    wait_ready();
    scramble();
    req_funct3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 13))
      0: req_addr = 12'h300;  1: req_addr = 12'h301;  2: req_addr = 12'h304;
      3: req_addr = 12'h305;  4: req_addr = 12'h340;  5: req_addr = 12'h341;
      6: req_addr = 12'h342;  7: req_addr = 12'h343;  8: req_addr = 12'hB00;
      9: req_addr = 12'hB80; 10: req_addr = 12'hC00; 11: req_addr = 12'h7C0;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 0) req_rs1_idx = 5'd0;
    trap_valid = tv; mret_valid = mv; req_valid = rv;
    @(posedge clk);
    @(negedge clk);
    trap_valid = 0; mret_valid = 0; req_valid = 0;
    scramble();
    wait_ready();
  endtask

  initial begin
    logic [31:0] rd;
    bit ill;
    int lat, r;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_illegal", resp_illegal, 0);
    check("rst_resp_rd_data", resp_rd_data, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_mie", mstatus_mie, 0);
    #2 rst_n = 1;

    do_req(3'b001, 12'h340, 32'hDEADBEEF, 5'd3, rd, ill, lat);
    check("rw_mscratch_rd", rd, 0); check("rw_latency", lat, 2); check("rw_ill", ill, 0);
    do_req(3'b010, 12'h340, 32'hFFFFFFFF, 5'd0, rd, ill, lat);
    check("rs_x0_rd", rd, 32'hDEADBEEF);
    do_req(3'b001, 12'h340, 32'hFF00FF00, 5'd4, rd, ill, lat);
    check("rw_unchanged_rd", rd, 32'hDEADBEEF);
    do_req(3'b111, 12'h340, 32'h0, 5'h0F, rd, ill, lat);
    check("rci_rd", rd, 32'hFF00FF00);
    do_req(3'b110, 12'h340, 32'h0, 5'h1F, rd, ill, lat);
    check("rsi_rd", rd, 32'hFF00FF00);
    do_req(3'b010, 12'h340, 32'h0, 5'd0, rd, ill, lat);
    check("rsi_result", rd, 32'hFF00FF1F);

    do_req(3'b001, 12'hC00, 32'h1234, 5'd1, rd, ill, lat);
    check("ro_write_ill", ill, 1); check("ro_write_rd", rd, 0);
    do_req(3'b010, 12'hC00, 32'h0, 5'd0, rd, ill, lat);
    check("c00_read_ill", ill, 1);
    do_req(3'b001, 12'h7C0, 32'h1234, 5'd1, rd, ill, lat);
    check("unimpl_ill", ill, 1);
    do_req(3'b000, 12'h340, 32'h1234, 5'd1, rd, ill, lat);
    check("bad_f3_ill", ill, 1);
    do_req(3'b010, 12'h340, 32'h0, 5'd0, rd, ill, lat);
    check("ill_no_change", rd, 32'hFF00FF1F);
    do_req(3'b001, 12'h301, 32'h0, 5'd1, rd, ill, lat);
    check("misa_rd", rd, 32'h40000100); check("misa_ill", ill, 0);

    do_req(3'b001, 12'h305, 32'h103, 5'd1, rd, ill, lat);
    do_req(3'b010, 12'h305, 32'h0, 5'd0, rd, ill, lat);
    check("mtvec_align", rd, 32'h100);
    do_req(3'b001, 12'h300, 32'h8, 5'd1, rd, ill, lat);
    check("mstatus_rst_rd", rd, 32'h1800);

    // trap, mret and a request all at once: trap first, then the held mret
    @(negedge clk);
    wait_ready();
    trap_valid = 1; mret_valid = 1; req_valid = 1;
    trap_pc = 32'h2003; trap_cause = 32'hB; trap_tval = 32'hABCD;
    req_funct3 = 3'b001; req_addr = 12'h340; req_rs1_data = 32'h55;
    @(negedge clk);
    check("trap_redir", redirect_valid, 1); check("trap_pc", redirect_pc, 32'h100);
    trap_valid = 0; req_valid = 0;
    @(negedge clk);
    check("trap_mie_clr", mstatus_mie, 0); check("trap_ready", req_ready, 1);
    @(negedge clk);
    check("mret_redir", redirect_valid, 1); check("mret_pc", redirect_pc, 32'h2000);
    mret_valid = 0;
    @(negedge clk);
    check("mret_mie", mstatus_mie, 1);
    do_req(3'b010, 12'h341, 32'h0, 5'd0, rd, ill, lat); check("mepc_rd", rd, 32'h2000);
    do_req(3'b010, 12'h342, 32'h0, 5'd0, rd, ill, lat); check("mcause_rd", rd, 32'hB);
    do_req(3'b010, 12'h343, 32'h0, 5'd0, rd, ill, lat); check("mtval_rd", rd, 32'hABCD);
    do_req(3'b010, 12'h300, 32'h0, 5'd0, rd, ill, lat); check("mstatus_after", rd, 32'h1888);
    do_req(3'b010, 12'h340, 32'h0, 5'd0, rd, ill, lat); check("loser_dropped", rd, 32'hFF00FF1F);

    // mcycle carry into the high half
    do_req(3'b001, 12'hB80, 32'h7, 5'd1, rd, ill, lat); check("mcycleh_old", rd, 0);
    do_req(3'b001, 12'hB00, 32'hFFFFFFF0, 5'd1, rd, ill, lat);
    repeat (20) @(negedge clk);
    do_req(3'b010, 12'hB80, 32'h0, 5'd0, rd, ill, lat); check("mcycle_carry", rd, 8);
    do_req(3'b001, 12'hB00, 32'h5, 5'd1, rd, ill, lat);
    do_req(3'b010, 12'hB00, 32'h0, 5'd0, rd, ill, lat);

    // reset while the access sits in READ
    @(negedge clk);
    wait_ready();
    req_valid = 1; req_funct3 = 3'b001; req_addr = 12'h340; req_rs1_data = 32'hAAAA5555;
    @(negedge clk);
    req_valid = 0;
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_resp", resp_valid, 0);
    #2 rst_n = 1;
    @(negedge clk);
    check("rst_mid_ready", req_ready, 1);
    do_req(3'b010, 12'h340, 32'h0, 5'd0, rd, ill, lat); check("rst_mid_mscratch", rd, 0);
    do_req(3'b010, 12'h305, 32'h0, 5'd0, rd, ill, lat); check("rst_mid_mtvec", rd, 0);
    do_req(3'b010, 12'h300, 32'h0, 5'd0, rd, ill, lat); check("rst_mid_mstatus", rd, 32'h1800);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      issue(r == 0, r == 1 || (r == 0 && $urandom_range(0, 1) == 1),
            r >= 2 || $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
